// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo block and its read-side consumers.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 2;
    localparam int FIFO_DEPTH      = 16;

    typedef enum logic {FILL, HOLD} state_t;

    // Width needed to hold an entry count from 0 to pack inclusive.
    function automatic int cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry whenever empty is low.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wptr, rptr;
    logic                  do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/fifo_packer.sv
// Drains a narrow show-ahead FIFO and packs PACK entries into one wide word
// presented on a valid/ready handshake; flush emits a partially filled word.
module fifo_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int PACK       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        dout,
    input  logic                         empty,
    output logic                         pop,
    input  logic                         flush,
    output logic [DATA_WIDTH*PACK-1:0]   out_data,
    output logic [cnt_width(PACK)-1:0]   out_count,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int            CW       = cnt_width(PACK);
    localparam int            IW       = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW-1:0] LAST     = CW'(PACK - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(PACK);

    state_t                          state, state_n;
    logic [CW-1:0]                   cnt, cnt_n;
    logic [PACK-1:0][DATA_WIDTH-1:0] acc, acc_n, word;
    logic [CW-1:0]                   word_cnt;
    logic                            load;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        word     = acc;
        word_cnt = '0;
        load     = 1'b0;
        pop      = 1'b0;
        case (state)
            FILL: begin
                if (flush && cnt != '0) begin
                    // Unused upper slots are already zero in acc.
                    load     = 1'b1;
                    word_cnt = cnt;
                    acc_n    = '0;
                    cnt_n    = '0;
                    state_n  = HOLD;
                end else if (!empty && !flush) begin
                    pop           = 1'b1;
                    word[cnt[IW-1:0]] = dout;
                    if (cnt == LAST) begin
                        load     = 1'b1;
                        word_cnt = FULL_CNT;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = HOLD;
                    end else begin
                        acc_n = word;
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = FILL;
                    acc_n   = '0;
                    cnt_n   = '0;
                    // Pop on the handshake edge keeps the FIFO draining at full rate.
                    if (!empty) begin
                        pop      = 1'b1;
                        acc_n[0] = dout;
                        cnt_n    = CW'(1);
                    end
                end
            end
            default: state_n = FILL;
        endcase
        if (!reset) pop = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            out_valid <= (state_n == HOLD);
            if (load) begin
                out_data  <= word;
                out_count <= word_cnt;
            end
        end
    end

endmodule

// File: tb/tb_fifo_packer.sv
// Randomized and directed bench for fifo_packer fed by a fifo instance; a queue
// model predicts pops and words, a separate monitor checks words on handshake.
module tb_fifo_packer;
    import fifo_pkg::*;

    localparam int DW    = 2;
    localparam int PACK  = 4;
    localparam int CW    = cnt_width(PACK);
    localparam int WW    = DW * PACK;
    localparam int DEPTH = 16;

    typedef struct {
        logic [WW-1:0] d;
        int            c;
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_rst = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full, empty, pop;
    logic [DW-1:0] dout;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [WW-1:0] out_data;
    logic [CW-1:0] out_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] part[$];
    bit            holding = 0;
    word_t         exp_q[$];
    logic [WW-1:0] got_q[$];
    int            got_c[$];
    int            npops = 0, run = 0, maxrun = 0;

    always #5 clk = ~clk;

    fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(fifo_rst), .push(push), .din(din), .full(full),
        .pop(pop), .dout(dout), .empty(empty)
    );

    fifo_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
        .clk(clk), .reset(reset), .dout(dout), .empty(empty), .pop(pop),
        .flush(flush), .out_data(out_data), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic word_t mk_word();
        word_t w;
        w.d = '0;
        for (int k = 0; k < part.size(); k++) w.d |= WW'(part[k]) << (k * DW);
        w.c = part.size();
        return w;
    endfunction

    // Reference model: evaluated mid-cycle, advanced as if the coming edge happened.
    always @(negedge clk) begin : model
        bit ep;
        if (!reset) begin
            chk("rst_pop", pop, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_count", out_count, 0);
            part.delete();
            exp_q.delete();
            holding = 0;
        end else begin
            chk("out_valid", out_valid, holding);
            ep = holding ? (out_ready && fq.size() > 0) : (!flush && fq.size() > 0);
            chk("pop", pop, ep);
            if (holding) begin
                if (out_ready) begin
                    holding = 0;
                    if (ep) part.push_back(fq.pop_front());
                end
            end else if (flush && part.size() > 0) begin
                exp_q.push_back(mk_word());
                part.delete();
                holding = 1;
            end else if (ep) begin
                part.push_back(fq.pop_front());
                if (part.size() == PACK) begin
                    exp_q.push_back(mk_word());
                    part.delete();
                    holding = 1;
                end
            end
        end
        if (pop === 1'b1) begin
            npops++;
            run++;
            if (run > maxrun) maxrun = run;
        end else run = 0;
        if (fifo_rst && push && fq.size() < DEPTH) fq.push_back(din);
    end

    logic          prev_hold = 0;
    logic [WW-1:0] prev_data;
    logic [CW-1:0] prev_cnt;

    always @(negedge clk) begin : monitor
        word_t w;
        if (!reset) prev_hold = 0;
        else begin
            if (prev_hold && out_valid) begin
                chk("hold_data_stable", out_data, prev_data);
                chk("hold_count_stable", out_count, prev_cnt);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
                else begin
                    w = exp_q.pop_front();
                    chk("word_data", out_data, w.d);
                    chk("word_count", out_count, w.c);
                    got_q.push_back(out_data);
                    got_c.push_back(int'(out_count));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_cnt  = out_count;
        end
    end

    task automatic cyc(input bit p, input logic [DW-1:0] d, input bit f, input bit r);
        @(posedge clk); #1;
        push = p; din = d; flush = f; out_ready = r;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) cyc(0, '0, 0, r);
    endtask

    initial begin
        int np0, nw0;
        logic [DW-1:0] seq8 [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

        repeat (3) @(posedge clk);
        #1 reset = 1'b1; fifo_rst = 1'b1;
        #1 chk("rel_valid", out_valid, 0);
        chk("rel_count", out_count, 0);

        // One full word, no backpressure.
        np0 = npops;
        for (int i = 0; i < 4; i++) cyc(1, seq8[i], 0, 1);
        idle(8, 1);
        chk("t1_pops", npops - np0, 4);
        chk("t1_words", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("t1_data", got_q[0], 8'h39);
            chk("t1_count", got_c[0], 4);
        end

        // Two back-to-back words with continuous pop.
        got_q.delete(); got_c.delete(); maxrun = 0;
        for (int i = 0; i < 8; i++) cyc(1, seq8[i], 0, 1);
        idle(8, 1);
        chk("t2_pop_run", maxrun, 8);
        chk("t2_words", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t2_word0", got_q[0], 8'h39);
            chk("t2_word1", got_q[1], 8'hE4);
        end

        // Backpressure: four pops then stall with the word held.
        np0 = npops;
        for (int i = 0; i < 6; i++) cyc(1, seq8[i], 0, 0);
        idle(10, 0);
        chk("t3_pops", npops - np0, 4);
        chk("t3_fifo_kept", empty, 0);
        chk("t3_held_data", out_data, 8'h39);
        chk("t3_held_valid", out_valid, 1);
        idle(10, 1);
        chk("t3_drained", empty, 1);
        cyc(0, '0, 1, 1);
        idle(4, 1);
        if (got_q.size() > 0) chk("t3_tail", got_q[$], 8'h04);

        // Flush of a partial word, then flush with nothing accumulated.
        cyc(1, 2'd1, 0, 1);
        cyc(1, 2'd2, 0, 1);
        idle(3, 1);
        cyc(0, '0, 1, 1);
        idle(4, 1);
        if (got_q.size() > 0) begin
            chk("t4_flush_data", got_q[$], 8'h09);
            chk("t4_flush_count", got_c[$], 2);
        end
        nw0 = got_q.size();
        cyc(0, '0, 1, 1);
        idle(5, 1);
        chk("t4_empty_flush", got_q.size(), nw0);

        // Flush while the FIFO still has data: no pop that cycle.
        cyc(1, 2'd3, 0, 1);
        cyc(1, 2'd2, 0, 1);
        cyc(0, '0, 1, 1);
        @(negedge clk);
        chk("t4_flush_nopop", pop, 0);
        chk("t4_flush_nonempty", empty, 0);
        idle(4, 1);
        cyc(0, '0, 1, 1);
        idle(4, 1);
        chk("t4_words", got_q.size(), nw0 + 2);
        if (got_q.size() == nw0 + 2) begin
            chk("t4_w_a", got_q[nw0], 8'h03);
            chk("t4_w_b", got_q[nw0 + 1], 8'h02);
        end

        // Reset after two pops discards the partial word.
        cyc(1, 2'd1, 0, 1);
        cyc(1, 2'd1, 0, 1);
        cyc(1, 2'd3, 0, 1);
        @(posedge clk); #1;
        push = 0; reset = 1'b0;
        #1 chk("t5_rst_data", out_data, 0);
        chk("t5_rst_pop", pop, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("t5_rel_valid", out_valid, 0);
        chk("t5_rel_data", out_data, 0);
        nw0 = got_q.size();
        cyc(1, 2'd2, 0, 1);
        cyc(1, 2'd1, 0, 1);
        cyc(1, 2'd0, 0, 1);
        idle(6, 1);
        chk("t5_words", got_q.size(), nw0 + 1);
        if (got_q.size() == nw0 + 1) chk("t5_fresh_word", got_q[nw0], 8'h1B);

        // Empty FIFO: nothing happens.
        np0 = npops;
        for (int i = 0; i < 10; i++) cyc(0, '0, 0, 1'($urandom_range(0, 1)));
        chk("t6_no_pop", npops - np0, 0);
        chk("t6_no_valid", out_valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 9) < 6) && (fq.size() < DEPTH - 2), 2'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        idle(30, 1);
        cyc(0, '0, 1, 1);
        idle(10, 1);
        chk("all_words_delivered", exp_q.size(), 0);
        chk("fifo_drained", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
